// File: rtl/cordic_iter_seq.sv
// cordic_iter_seq: sequential CORDIC vectoring engine.
// The engine registers one (x, y) operand pair and performs one shift-add
// micro-rotation per clock for ITER clocks. The rotation direction comes
// from an external combinational decision stage, which is fed the 4 MSBs of
// the x/y registers through xm_pad/ym_pad.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. The producer holds its data and valid until that edge. The
// consumer may raise or lower ready at any time. in_ready_pad is high only in
// IDLE, and out_valid_pad is high only in DONE. A result therefore never
// retires on the same edge that a new operand is accepted.
//
// Build option: define CORDIC_ITER_SEQ_SAT_EN to saturate each x/y update on
// signed overflow. Without it, the updates wrap modulo 2^WIDTH.
module cordic_iter_seq #(
  parameter int WIDTH = 16,
  parameter int ITER  = 12
) (
  input  logic             clk_pad,
  input  logic             rst_n_pad,
  input  logic             in_valid_pad,
  output logic             in_ready_pad,
  input  logic [WIDTH-1:0] x_in_pad,
  input  logic [WIDTH-1:0] y_in_pad,
  output logic [3:0]       xm_pad,
  output logic [3:0]       ym_pad,
  input  logic             d_pad,
  input  logic             dn_pad,
  output logic             out_valid_pad,
  input  logic             out_ready_pad,
  output logic [WIDTH-1:0] x_out_pad,
  output logic [ITER-1:0]  dir_out_pad,
  output logic             err_pad,
  output logic [1:0]       dbg_state_pad
);

  localparam int IW = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [IW-1:0] LAST_I = IW'(ITER - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic signed [WIDTH-1:0]  r_x;
  logic signed [WIDTH-1:0]  r_y;
  logic [WIDTH-1:0]         r_x_out;
  logic [IW-1:0]            r_i;
  logic [ITER-1:0]          r_dir;
  logic                     r_err;

  logic                     w_accept;
  logic                     w_retire;
  logic                     w_last;
  logic                     w_dec_sub;
  logic                     w_dec_add;
  logic                     w_dec_bad;
  logic signed [WIDTH-1:0]  w_x_sh;
  logic signed [WIDTH-1:0]  w_y_sh;
  logic signed [WIDTH-1:0]  w_x_plus;
  logic signed [WIDTH-1:0]  w_x_minus;
  logic signed [WIDTH-1:0]  w_y_plus;
  logic signed [WIDTH-1:0]  w_y_minus;
  logic signed [WIDTH-1:0]  w_x_nxt;
  logic signed [WIDTH-1:0]  w_y_nxt;
  logic                     w_dir_bit;

  // Handshake qualifiers and the decoded decision pair.
  assign w_accept  = in_valid_pad & in_ready_pad;
  assign w_retire  = out_valid_pad & out_ready_pad;
  assign w_last    = (r_i == LAST_I);
  assign w_dec_sub = d_pad & ~dn_pad;
  assign w_dec_add = ~d_pad & dn_pad;
  assign w_dec_bad = ~(w_dec_sub | w_dec_add);

  // Both shifted terms use the pre-update registers.
  assign w_x_sh = r_x >>> r_i;
  assign w_y_sh = r_y >>> r_i;

`ifdef CORDIC_ITER_SEQ_SAT_EN
  // Clamp a WIDTH+1 bit sum back to WIDTH bits. The two top bits differ
  // only when the sum overflowed.
  function automatic logic [WIDTH-1:0] f_sat(input logic [WIDTH:0] v);
    logic [WIDTH-1:0] r;
    if (v[WIDTH] != v[WIDTH-1]) begin
      r = v[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      r = v[WIDTH-1:0];
    end
    return r;
  endfunction

  logic [WIDTH:0] w_x_plus_ext;
  logic [WIDTH:0] w_x_minus_ext;
  logic [WIDTH:0] w_y_plus_ext;
  logic [WIDTH:0] w_y_minus_ext;

  assign w_x_plus_ext  = {r_x[WIDTH-1], r_x} + {w_y_sh[WIDTH-1], w_y_sh};
  assign w_x_minus_ext = {r_x[WIDTH-1], r_x} - {w_y_sh[WIDTH-1], w_y_sh};
  assign w_y_plus_ext  = {r_y[WIDTH-1], r_y} + {w_x_sh[WIDTH-1], w_x_sh};
  assign w_y_minus_ext = {r_y[WIDTH-1], r_y} - {w_x_sh[WIDTH-1], w_x_sh};
  assign w_x_plus      = f_sat(w_x_plus_ext);
  assign w_x_minus     = f_sat(w_x_minus_ext);
  assign w_y_plus      = f_sat(w_y_plus_ext);
  assign w_y_minus     = f_sat(w_y_minus_ext);
`else
  assign w_x_plus  = r_x + w_y_sh;
  assign w_x_minus = r_x - w_y_sh;
  assign w_y_plus  = r_y + w_x_sh;
  assign w_y_minus = r_y - w_x_sh;
`endif

  // Select the micro-rotation. An invalid pair holds x/y and records a 0.
  always_comb begin
    w_x_nxt   = r_x;
    w_y_nxt   = r_y;
    w_dir_bit = 1'b0;
    if (w_dec_sub) begin
      w_x_nxt   = w_x_plus;
      w_y_nxt   = w_y_minus;
      w_dir_bit = 1'b1;
    end else if (w_dec_add) begin
      w_x_nxt   = w_x_minus;
      w_y_nxt   = w_y_plus;
    end
  end

  // Next-state logic and the state-decoded handshake outputs.
  always_comb begin
    w_state_nxt   = r_state;
    in_ready_pad  = 1'b0;
    out_valid_pad = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready_pad = 1'b1;
        if (in_valid_pad) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (w_last) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        out_valid_pad = 1'b1;
        if (out_ready_pad) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_pad or negedge rst_n_pad) begin
    if (!rst_n_pad) r_state <= ST_IDLE;
    else            r_state <= w_state_nxt;
  end

  // Operand load, one micro-rotation per RUN cycle, and result capture.
  always_ff @(posedge clk_pad or negedge rst_n_pad) begin
    if (!rst_n_pad) begin
      r_x     <= '0;
      r_y     <= '0;
      r_x_out <= '0;
      r_i     <= '0;
      r_dir   <= '0;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      r_x   <= x_in_pad;
      r_y   <= y_in_pad;
      r_i   <= '0;
      r_dir <= '0;
      r_err <= 1'b0;
    end else if (r_state == ST_RUN) begin
      r_x        <= w_x_nxt;
      r_y        <= w_y_nxt;
      r_dir[r_i] <= w_dir_bit;
      if (w_dec_bad) r_err <= 1'b1;
      if (w_last) begin
        r_i     <= '0;
        r_x_out <= w_x_nxt;
      end else begin
        r_i <= r_i + IW'(1);
      end
    end
  end

  // x_out only changes when a result completes, so it holds steady in DONE.
  assign x_out_pad     = r_x_out;
  assign dir_out_pad   = r_dir;
  assign err_pad       = r_err;
  assign xm_pad        = r_x[WIDTH-1 -: 4];
  assign ym_pad        = r_y[WIDTH-1 -: 4];
  assign dbg_state_pad = r_state;

endmodule
